// File: rtl/handshake_arbiter.sv
// Round-robin arbiter feeding a one-entry output register for a shared datapath.
// Define HANDSHAKE_ARBITER_ASSERT_EN to compile in the protocol assertions.
module handshake_arbiter #(
  parameter int WIDTH = 5,
  parameter int N     = 3
) (
  input  logic                 CLK,
  input  logic                 ASYNCRESETN,
  input  logic [N-1:0]         req_valid,
  output logic [N-1:0]         req_ready,
  input  logic [N*WIDTH-1:0]   req_in1,
  input  logic [N*WIDTH-1:0]   req_in2,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_in1,
  output logic [WIDTH-1:0]     out_in2,
  output logic [1:0]           out_id,
  output logic                 busy
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  localparam logic [1:0] LAST_RST = 2'(N - 1);

  state_t            r_state;
  logic [WIDTH-1:0]  r_in1;
  logic [WIDTH-1:0]  r_in2;
  logic [1:0]        r_id;
  logic [1:0]        r_last;

  logic              w_free;
  logic              w_any;
  logic              w_xfer;
  logic [1:0]        w_gnt;
  logic [N-1:0]      w_onehot;
  logic [WIDTH-1:0]  w_sel_in1;
  logic [WIDTH-1:0]  w_sel_in2;

  // NOTE: every signal gets a default at the top of the block so no path leaves it unassigned (no latch).
  always_comb begin
    w_free    = (r_state == EMPTY) || out_ready;
    w_any     = 1'b0;
    w_gnt     = 2'd0;
    w_onehot  = '0;
    w_sel_in1 = '0;
    w_sel_in2 = '0;
    // Search priority starts just after the last winner and wraps.
    for (int k = 1; k <= N; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!w_any && req_valid[i] && (((int'(r_last) + k) % N) == i)) begin
          w_any = 1'b1;
          w_gnt = 2'(i);
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      if (w_gnt == 2'(i)) begin
        w_onehot[i] = 1'b1;
        w_sel_in1   = req_in1[i*WIDTH +: WIDTH];
        w_sel_in2   = req_in2[i*WIDTH +: WIDTH];
      end
    end
  end

  assign w_xfer = w_free && w_any;
  // Reset gates the combinational ready so it drops without waiting for an edge.
  assign req_ready = (ASYNCRESETN && w_xfer) ? w_onehot : '0;

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      r_state <= EMPTY;
      r_in1   <= '0;
      r_in2   <= '0;
      r_id    <= 2'd0;
      r_last  <= LAST_RST;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_xfer) begin
            r_in1   <= w_sel_in1;
            r_in2   <= w_sel_in2;
            r_id    <= w_gnt;
            r_last  <= w_gnt;
            r_state <= FULL;
          end
        end
        FULL: begin
          if (w_xfer) begin
            r_in1  <= w_sel_in1;
            r_in2  <= w_sel_in2;
            r_id   <= w_gnt;
            r_last <= w_gnt;
          end else if (out_ready) begin
            r_state <= EMPTY;
          end
        end
        default: r_state <= EMPTY;
      endcase
    end
  end

  assign out_valid = (r_state == FULL);
  assign busy      = (r_state == FULL);
  assign out_in1   = r_in1;
  assign out_in2   = r_in2;
  assign out_id    = r_id;

`ifdef HANDSHAKE_ARBITER_ASSERT_EN
  a_ready_onehot: assert property (@(posedge CLK) disable iff (!ASYNCRESETN)
    $onehot0(req_ready));

  for (genvar gi = 0; gi < N; gi++) begin : g_req_hold
    a_valid_hold: assert property (@(posedge CLK) disable iff (!ASYNCRESETN)
      (req_valid[gi] && !req_ready[gi]) |=>
        (req_valid[gi] && $stable(req_in1[gi*WIDTH +: WIDTH]) &&
         $stable(req_in2[gi*WIDTH +: WIDTH])));
  end

  a_out_stable: assert property (@(posedge CLK) disable iff (!ASYNCRESETN)
    (out_valid && !out_ready) |=>
      (out_valid && $stable(out_in1) && $stable(out_in2) && $stable(out_id)));

  a_id_range: assert property (@(posedge CLK) disable iff (!ASYNCRESETN)
    (int'(out_id) < N));
`endif

endmodule

// File: doc/handshake_arbiter.md
HANDSHAKE_ARBITER -- requirements
Module: handshake_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 5, giving the per-operand data width (in1/in2 of the shared datapath).
REQ-002 The block SHALL have parameter N, default 3, giving the requester count; legal range 2..4.
REQ-003 The block SHALL have port CLK, input, 1 bit, the single clock; all state is updated on its rising edge.
REQ-004 The block SHALL have port ASYNCRESETN, input, 1 bit; reset is asynchronous and active-low.
REQ-005 The block SHALL have port req_valid, input, N bits, the per-requester valid.
REQ-006 The block SHALL have port req_ready, output, N bits, the per-requester ready.
REQ-007 The block SHALL have port req_in1, input, N*WIDTH bits; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-008 The block SHALL have port req_in2, input, N*WIDTH bits, packed the same way as req_in1.
REQ-009 The block SHALL have port out_valid, output, 1 bit, the valid toward the shared datapath.
REQ-010 The block SHALL have port out_ready, input, 1 bit, the ready from the shared datapath.
REQ-011 The block SHALL have port out_in1, output, WIDTH bits, carrying the registered operand 1.
REQ-012 The block SHALL have port out_in2, output, WIDTH bits, carrying the registered operand 2.
REQ-013 The block SHALL have port out_id, output, 2 bits, giving the index of the requester whose data is held.
REQ-014 The block SHALL have port busy, output, 1 bit, equal to out_valid.

Function
REQ-015 The block SHALL hold a one-entry output register with two states: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-016 A slot SHALL be free in a cycle when state=EMPTY, or when state=FULL and out_ready=1.
REQ-017 The block SHALL grant when a slot is free and |req_valid=1, selecting exactly one requester by round-robin.
REQ-018 The round-robin search SHALL start at index last+1 mod N; last is the most recently granted index.
REQ-019 req_ready SHALL be combinational and one-hot-or-zero: req_ready[g]=1 only for the granted g in a grant cycle, otherwise all bits are 0.
REQ-020 A transfer on requester i occurs when req_valid[i] and req_ready[i] are both 1. On that edge the block SHALL capture in1, in2 and out_id=i, set last=i and enter or stay in FULL.
REQ-021 Latency SHALL be one cycle: data accepted at edge t appears with out_valid=1 after edge t.
REQ-022 In FULL with out_ready=0, out_valid, out_in1, out_in2 and out_id SHALL hold stable, and req_ready SHALL be all 0.
REQ-023 In FULL with out_ready=1 and no request, the block SHALL go to EMPTY; out_in1, out_in2 and out_id keep their values.
REQ-024 In FULL with out_ready=1 and a request present, drain and refill SHALL happen on the same edge, sustaining one transfer per cycle.
REQ-025 last SHALL wrap from N-1 to 0.
REQ-026 When only one requester is valid, it SHALL be granted regardless of last.
REQ-027 The block SHALL not depend on out_ready being low while out_valid is low.

Reset
REQ-028 While ASYNCRESETN=0, the block SHALL force, without waiting for a clock edge: state=EMPTY, out_valid=0, busy=0, req_ready=0, out_in1=0, out_in2=0, out_id=0, last=N-1.
REQ-029 A reset asserted mid-transfer SHALL discard the held entry; release SHALL take effect at the first rising CLK edge after deassertion.

Configuration
REQ-030 The block SHALL support the macro HANDSHAKE_ARBITER_ASSERT_EN. When defined, concurrent assertions clocked on CLK and disabled while ASYNCRESETN=0 SHALL check:
- req_ready is one-hot-or-zero;
- req_valid[i] stays high, with data stable, until its transfer;
- out_valid, out_in1, out_in2 and out_id are stable while out_valid=1 and out_ready=0;
- out_id < N.
REQ-031 When HANDSHAKE_ARBITER_ASSERT_EN is undefined, the block SHALL contain no assertions; functional behaviour is identical.

Verification
REQ-032 Reset: drive ASYNCRESETN=0 mid-cycle with FULL state -> out_valid=0, req_ready=000, out_id=0 immediately, before any edge.
REQ-033 Single requester: req_valid=010, in1=5'h1F, in2=5'h03, out_ready=1 -> req_ready=010 at t; after edge t: out_valid=1, out_in1=1F, out_in2=03, out_id=1.
REQ-034 Fairness: req_valid=111 held, out_ready=1 for 6 cycles -> grants 0,1,2,0,1,2 and one transfer per cycle.
REQ-035 Backpressure: FULL with out_id=2, out_ready=0 for 4 cycles, req_valid=011 -> outputs stable, req_ready=000; when out_ready=1, requester 0 is granted (wrap from last=2).
REQ-036 Drain to empty: FULL, out_ready=1, req_valid=000 -> out_valid=0 next cycle and out_in1 retains its value.
REQ-037 Assertion build: with HANDSHAKE_ARBITER_ASSERT_EN defined, drop req_valid[1] before its ready -> valid-stability assertion fires; the same stimulus without the macro -> no failure.
